// File: rtl/ballot_collector.sv
// rtl/ballot_collector.sv - ballot front-end for voting_rule: collect, evaluate, hold, tally
module ballot_collector #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vote_w,
  input  logic             vote_n,
  input  logic             vote_o,
  input  logic             cast_w,
  input  logic             cast_n,
  input  logic             cast_o,
  output logic             rule_w,
  output logic             rule_n,
  output logic             rule_o,
  input  logic             rule_a,
  input  logic             rule_b,
  input  logic             rule_c,
  input  logic             rule_d,
  output logic [3:0]       result,
  output logic             result_valid,
  input  logic             result_ack,
  output logic             timed_out,
  output logic             busy,
  output logic [CNT_W-1:0] tally_a,
  output logic [CNT_W-1:0] tally_b,
  output logic [CNT_W-1:0] tally_c,
  output logic [CNT_W-1:0] tally_d
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_EVAL    = 2'd2;
  localparam logic [1:0] S_HOLD    = 2'd3;

  logic [1:0]    state;
  logic [2:0]    flag;        // {w, n, o}: voter has cast in this ballot
  logic [2:0]    flag_next;
  logic [TW-1:0] timer;
  logic          complete;
  logic          last_cycle;

  // Casts accepted on this edge count toward completion, so a last-cycle cast beats the timeout.
  assign flag_next  = flag | {cast_w, cast_n, cast_o};
  assign complete   = &flag_next;
  assign last_cycle = (timer == T_LAST);
  assign busy       = (state != S_IDLE);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      flag         <= '0;
      timer        <= '0;
      rule_w       <= 1'b0;
      rule_n       <= 1'b0;
      rule_o       <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      timed_out    <= 1'b0;
      tally_a      <= '0;
      tally_b      <= '0;
      tally_c      <= '0;
      tally_d      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_COLLECT;
            flag      <= '0;
            timer     <= '0;
            rule_w    <= 1'b0;
            rule_n    <= 1'b0;
            rule_o    <= 1'b0;
            timed_out <= 1'b0;
          end
        end
        S_COLLECT: begin
          timer <= timer + TW'(1);
          if (cast_w && !flag[2]) rule_w <= vote_w;
          if (cast_n && !flag[1]) rule_n <= vote_n;
          if (cast_o && !flag[0]) rule_o <= vote_o;
          flag <= flag_next;
          if (complete) begin
            state <= S_EVAL;
          end else if (last_cycle) begin
            timed_out <= 1'b1;
            state     <= S_EVAL;
          end
        end
        S_EVAL: begin
          result       <= {rule_a, rule_b, rule_c, rule_d};
          result_valid <= 1'b1;
          tally_a      <= sat_inc(tally_a, rule_a);
          tally_b      <= sat_inc(tally_b, rule_b);
          tally_c      <= sat_inc(tally_c, rule_c);
          tally_d      <= sat_inc(tally_d, rule_d);
          state        <= S_HOLD;
        end
        S_HOLD: begin
          if (result_ack) begin
            result_valid <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
